// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op encoding and sizing helper for the register stack file
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_PUSH      = 3'd1,
        OP_POP       = 3'd2,
        OP_REPLACE   = 3'd3,
        OP_POP2_PUSH = 3'd4,
        OP_WRITE_ABS = 3'd5
    } stack_op_t;

    // Ceiling log2 that never returns less than 1, so a two-entry stack still gets a 1-bit index.
    function automatic int safe_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/stack_ptr_ctrl.sv
// rtl/stack_ptr_ctrl.sv - stack pointer, legality checks, sticky errors and write strobe generation
module stack_ptr_ctrl
    import stack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = safe_clog2(DEPTH),
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [2:0]    op,
    input  logic [AW-1:0] abs_sel,
    input  logic          clr_err,
    output logic [DW-1:0] sp,
    output logic          wr_en,
    output logic [AW-1:0] wr_idx,
    output logic          err_ovf,
    output logic          err_udf
);

    logic [DW-1:0] sp_next;
    logic          set_ovf;
    logic          set_udf;
    logic          is_full;
    logic          has_one;
    logic          has_two;
    logic          abs_ok;

    assign is_full = (sp == DW'(DEPTH));
    assign has_one = (sp != '0);
    assign has_two = (sp > DW'(1));
    assign abs_ok  = (32'(abs_sel) < DEPTH);

    // Decode the op against current occupancy; a faulting op only raises its error flag.
    always_comb begin
        sp_next = sp;
        wr_en   = 1'b0;
        wr_idx  = '0;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        case (stack_op_t'(op))
            OP_PUSH: begin
                if (!is_full) begin
                    wr_en   = 1'b1;
                    wr_idx  = AW'(sp);
                    sp_next = sp + DW'(1);
                end else begin
                    set_ovf = 1'b1;
                end
            end
            OP_POP: begin
                if (has_one) begin
                    sp_next = sp - DW'(1);
                end else begin
                    set_udf = 1'b1;
                end
            end
            OP_REPLACE: begin
                if (has_one) begin
                    wr_en  = 1'b1;
                    wr_idx = AW'(sp - DW'(1));
                end else begin
                    set_udf = 1'b1;
                end
            end
            OP_POP2_PUSH: begin
                if (has_two) begin
                    wr_en   = 1'b1;
                    wr_idx  = AW'(sp - DW'(2));
                    sp_next = sp - DW'(1);
                end else begin
                    set_udf = 1'b1;
                end
            end
            OP_WRITE_ABS: begin
                if (abs_ok) begin
                    wr_en  = 1'b1;
                    wr_idx = abs_sel;
                end
            end
            default: begin
            end
        endcase
    end

    // Commit the pointer; a new error beats a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp      <= '0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            sp      <= sp_next;
            err_ovf <= set_ovf | (err_ovf & ~clr_err);
            err_udf <= set_udf | (err_udf & ~clr_err);
        end
    end

endmodule

// File: rtl/reg_stack_file.sv
// rtl/reg_stack_file.sv - operand stack register file with absolute-index access
module reg_stack_file
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = safe_clog2(DEPTH),
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    abs_sel,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rd_top,
    output logic [WIDTH-1:0] rd_next,
    output logic [WIDTH-1:0] rd_abs,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             err_ovf,
    output logic             err_udf
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DW-1:0]    sp;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    next_idx;

    stack_ptr_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .op      (op),
        .abs_sel (abs_sel),
        .clr_err (clr_err),
        .sp      (sp),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .err_ovf (err_ovf),
        .err_udf (err_udf)
    );

    // Storage array; popped entries keep their contents until overwritten.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= wr_data;
        end
    end

    assign depth = sp;
    assign full  = (sp == DW'(DEPTH));
    assign empty = (sp == '0);

    // Read ports come straight from registered state, so writes show up one cycle later.
    always_comb begin
        top_idx  = AW'(sp - DW'(1));
        next_idx = AW'(sp - DW'(2));
        rd_top   = (sp != '0)     ? regs[top_idx]  : '0;
        rd_next  = (sp > DW'(1))  ? regs[next_idx] : '0;
        rd_abs   = (32'(abs_sel) < DEPTH) ? regs[abs_sel] : '0;
    end

endmodule

// File: tb/tb_reg_stack_file.sv
// tb/tb_reg_stack_file.sv - scoreboard bench for reg_stack_file
module tb_reg_stack_file;
    import stack_pkg::*;

    logic       clock;
    logic       reset_n;
    logic [2:0] op;
    logic [7:0] wr_data;
    logic [2:0] abs_sel;
    logic       clr_err;
    logic [7:0] rd_top;
    logic [7:0] rd_next;
    logic [7:0] rd_abs;
    logic [3:0] depth;
    logic       full;
    logic       empty;
    logic       err_ovf;
    logic       err_udf;

    typedef struct {
        string tag;
        int    d;
        int    top;
        int    nxt;
        int    ab;
        int    ovf;
        int    udf;
    } exp_t;

    exp_t sb [$];
    int   vectors    = 0;
    int   miscompares = 0;

    reg_stack_file #(.WIDTH(8), .DEPTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .op      (op),
        .wr_data (wr_data),
        .abs_sel (abs_sel),
        .clr_err (clr_err),
        .rd_top  (rd_top),
        .rd_next (rd_next),
        .rd_abs  (rd_abs),
        .depth   (depth),
        .full    (full),
        .empty   (empty),
        .err_ovf (err_ovf),
        .err_udf (err_udf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_state(input exp_t e);
        chk({e.tag, ".depth"}, int'(depth), e.d);
        chk({e.tag, ".top"}, int'(rd_top), e.top);
        chk({e.tag, ".next"}, int'(rd_next), e.nxt);
        chk({e.tag, ".abs"}, int'(rd_abs), e.ab);
        chk({e.tag, ".full"}, int'(full), (e.d == 8) ? 1 : 0);
        chk({e.tag, ".empty"}, int'(empty), (e.d == 0) ? 1 : 0);
        chk({e.tag, ".ovf"}, int'(err_ovf), e.ovf);
        chk({e.tag, ".udf"}, int'(err_udf), e.udf);
    endtask

    // Monitor: once the state after each edge has settled, pop and compare the next expectation.
    always @(posedge clock) begin
        #3;
        if (sb.size() > 0) begin
            chk_state(sb.pop_front());
        end
    end

    task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] dat,
                         input logic [2:0] sel, input logic clr,
                         input int d, input int t, input int n, input int a,
                         input int ov, input int ud, input int pre_top);
        exp_t e;
        @(negedge clock);
        op      = o;
        wr_data = dat;
        abs_sel = sel;
        clr_err = clr;
        if (pre_top >= 0) begin
            #2;
            chk({tag, ".pre_top"}, int'(rd_top), pre_top);
        end
        @(posedge clock);
        #1;
        e.tag = tag; e.d = d; e.top = t; e.nxt = n; e.ab = a; e.ovf = ov; e.udf = ud;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        reset_n = 1'b0;
        op      = 3'd0;
        wr_data = 8'h00;
        abs_sel = 3'd0;
        clr_err = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        z.tag = "reset"; z.d = 0; z.top = 0; z.nxt = 0; z.ab = 0; z.ovf = 0; z.udf = 0;
        chk_state(z);
        reset_n = 1'b1;

        // basic pushes
        do_op("push11", OP_PUSH, 8'h11, 3'd0, 1'b0, 1, 8'h11, 0,     8'h11, 0, 0, -1);
        do_op("push22", OP_PUSH, 8'h22, 3'd0, 1'b0, 2, 8'h22, 8'h11, 8'h11, 0, 0, -1);
        do_op("push33", OP_PUSH, 8'h33, 3'd0, 1'b0, 3, 8'h33, 8'h22, 8'h11, 0, 0, -1);
        // binary op and replace
        do_op("pop2push", OP_POP2_PUSH, 8'h55, 3'd0, 1'b0, 2, 8'h55, 8'h11, 8'h11, 0, 0, -1);
        do_op("replace",  OP_REPLACE,   8'hAA, 3'd0, 1'b0, 2, 8'hAA, 8'h11, 8'h11, 0, 0, -1);
        do_op("pop_a", OP_POP, 8'h00, 3'd0, 1'b0, 1, 8'h11, 0, 8'h11, 0, 0, -1);
        do_op("pop_b", OP_POP, 8'h00, 3'd0, 1'b0, 0, 0,     0, 8'h11, 0, 0, -1);
        // fill to full, then overflow
        for (int k = 1; k <= 8; k++) begin
            do_op("fill", OP_PUSH, 8'(k), 3'd0, 1'b0, k, k, (k >= 2) ? k - 1 : 0, 8'h01, 0, 0, -1);
        end
        do_op("ovf",     OP_PUSH, 8'h09, 3'd0, 1'b0, 8, 8'h08, 8'h07, 8'h01, 1, 0, -1);
        do_op("clr_ovf", OP_NOP,  8'h00, 3'd0, 1'b1, 8, 8'h08, 8'h07, 8'h01, 0, 0, -1);
        do_op("rsvd6",   3'd6,    8'hFF, 3'd0, 1'b0, 8, 8'h08, 8'h07, 8'h01, 0, 0, -1);
        // drain to empty, then underflow cases
        for (int j = 7; j >= 0; j--) begin
            do_op("drain", OP_POP, 8'h00, 3'd0, 1'b0, j, j, (j >= 2) ? j - 1 : 0, 8'h01, 0, 0, -1);
        end
        do_op("udf_pop",   OP_POP,       8'h00, 3'd0, 1'b0, 0, 0,     0, 8'h01, 0, 1, -1);
        do_op("push7f",    OP_PUSH,      8'h7F, 3'd0, 1'b0, 1, 8'h7F, 0, 8'h7F, 0, 1, -1);
        do_op("udf_p2p",   OP_POP2_PUSH, 8'h00, 3'd0, 1'b0, 1, 8'h7F, 0, 8'h7F, 0, 1, -1);
        do_op("pop7f",     OP_POP,       8'h00, 3'd0, 1'b0, 0, 0,     0, 8'h7F, 0, 1, -1);
        do_op("clr_vs_udf",OP_POP,       8'h00, 3'd0, 1'b1, 0, 0,     0, 8'h7F, 0, 1, -1);
        // absolute writes, no bypass
        do_op("pushab", OP_PUSH, 8'hAB, 3'd0, 1'b0, 1, 8'hAB, 0,     8'hAB, 0, 1, -1);
        do_op("pushcd", OP_PUSH, 8'hCD, 3'd0, 1'b0, 2, 8'hCD, 8'hAB, 8'hAB, 0, 1, -1);
        do_op("wabs1",  OP_WRITE_ABS, 8'hC3, 3'd1, 1'b0, 2, 8'hC3, 8'hAB, 8'hC3, 0, 1, 8'hCD);
        do_op("wabs5",  OP_WRITE_ABS, 8'h99, 3'd5, 1'b0, 2, 8'hC3, 8'hAB, 8'h99, 0, 1, -1);
        // build depth 4 with both errors set
        for (int k = 3; k <= 8; k++) begin
            do_op("refill", OP_PUSH, 8'(8'h41 + k), 3'd0, 1'b0, k, 8'h41 + k,
                  (k == 3) ? 8'hC3 : 8'h40 + k, 8'hAB, 0, 1, -1);
        end
        do_op("ovf2", OP_PUSH, 8'h50, 3'd0, 1'b0, 8, 8'h49, 8'h48, 8'hAB, 1, 1, -1);
        for (int j = 7; j >= 4; j--) begin
            do_op("shrink", OP_POP, 8'h00, 3'd0, 1'b0, j, 8'h41 + j, 8'h40 + j, 8'hAB, 1, 1, -1);
        end
        // asynchronous reset between edges
        @(negedge clock);
        op      = OP_PUSH;
        wr_data = 8'hEE;
        abs_sel = 3'd0;
        clr_err = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        z.tag = "async_rst";
        chk_state(z);
        abs_sel = 3'd5;
        #1;
        chk("async_rst.abs5", int'(rd_abs), 0);
        @(posedge clock);
        #1;
        chk("rst_hold.depth", int'(depth), 0);
        chk("rst_hold.top", int'(rd_top), 0);
        @(negedge clock);
        reset_n = 1'b1;
        op      = OP_NOP;
        do_op("post_rst", OP_PUSH, 8'h12, 3'd5, 1'b0, 1, 8'h12, 0, 0, 0, 0, -1);

        begin
            int budget;
            budget = 0;
            while (sb.size() > 0 && budget < 10) begin
                @(posedge clock);
                budget++;
            end
            #5;
            if (sb.size() > 0) begin
                vectors++;
                miscompares++;
                $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
